// File: rtl/add_seq_ctrl.sv
// Serial adder: one WIDTH-bit slice per cycle, LSB first; result valid NSLICE cycles after accept, held until out_ready.
// Accepts only in IDLE (in_ready low in RUN/DONE). ADD_SEQ_SUB_EN adds a sub input for a-b.
module add_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int NSLICE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*NSLICE-1:0] a,
  input  logic [WIDTH*NSLICE-1:0] b,
`ifdef ADD_SEQ_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*NSLICE-1:0] sum,
  output logic                    cout,
  output logic                    busy
);

  localparam int OPW = WIDTH * NSLICE;
  localparam int CW  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [OPW-1:0] r_a_sh;
  logic [OPW-1:0] r_b_sh;
  logic [OPW-1:0] r_sum;
  logic           r_carry;
  logic           r_cout;
  logic           r_out_valid;
  logic [CW-1:0]  r_cnt;
  logic [WIDTH:0] w_add;
  logic [OPW-1:0] w_sum_nxt;
  logic           w_accept;
  logic           w_last;
  logic           w_sub;

`ifdef ADD_SEQ_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(NSLICE - 1));
  assign w_add    = {1'b0, r_a_sh[WIDTH-1:0]} + {1'b0, r_b_sh[WIDTH-1:0]}
                  + {{WIDTH{1'b0}}, r_carry};

  // Each slice enters at the top so the first one lands in the LSBs after NSLICE shifts.
  generate
    if (NSLICE == 1) begin : g_single
      assign w_sum_nxt = w_add[WIDTH-1:0];
    end else begin : g_multi
      assign w_sum_nxt = {w_add[WIDTH-1:0], r_sum[OPW-1:WIDTH]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert b on capture and seed the carry.
      r_a_sh  <= a;
      r_b_sh  <= w_sub ? ~b : b;
      r_carry <= w_sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh  <= r_a_sh >> WIDTH;
      r_b_sh  <= r_b_sh >> WIDTH;
      r_carry <= w_add[WIDTH];
      r_cnt   <= r_cnt + 1'b1;
      r_sum   <= w_sum_nxt;
      if (w_last) begin
        r_cout      <= w_add[WIDTH];
        r_out_valid <= 1'b1;
      end
    end else if ((r_state == DONE) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (WIDTH=4, NSLICE=4) with a result scoreboard.
module tb_add_seq_ctrl;
  localparam int W   = 4;
  localparam int N   = 4;
  localparam int OPW = W * N;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OPW-1:0] a = '0;
  logic [OPW-1:0] b = '0;
  logic           sub_i = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [OPW-1:0] sum;
  logic           cout;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;
  logic [OPW:0] sb_q[$];
  logic [OPW:0] last_e = '0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WIDTH(W), .NSLICE(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
`ifdef ADD_SEQ_SUB_EN
    .sub      (sub_i),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for one edge; the DUT must be in IDLE.
  task automatic accept(input logic [OPW-1:0] av, input logic [OPW-1:0] bv,
                        input logic sv, input bit push);
    a = av; b = bv; sub_i = sv; in_valid = 1'b1;
    if (push)
      sb_q.push_back(sv ? ({1'b0, av} + {1'b0, ~bv} + 17'd1) : ({1'b0, av} + {1'b0, bv}));
    tick();
    in_valid = 1'b0;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_result(input int exp_lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, exp_lat);
    chk("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
    if (sb_q.size() > 0) begin
      last_e = sb_q.pop_front();
      chk("sum", {16'd0, sum}, {16'd0, last_e[OPW-1:0]});
      chk("cout", {31'd0, cout}, {31'd0, last_e[OPW]});
    end
    chk("done_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_busy", {31'd0, busy}, 32'd0);
    chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic add and carry ripple cases
    accept(16'h1234, 16'h0FFF, 1'b0, 1'b1);
    wait_result(4);
    chk("basic_sum_const", {16'd0, sum}, 32'h2233);
    handshake();
    accept(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    wait_result(4);
    chk("ripple_cout_const", {31'd0, cout}, 32'd1);
    handshake();
    accept(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    wait_result(4);
    chk("ffff_sum_const", {16'd0, sum}, 32'hFFFE);
    handshake();

    // Backpressure: result held, next request waits for handshake plus one cycle
    out_ready = 1'b0;
    accept(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    wait_result(4);
    a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", {16'd0, sum}, {16'd0, last_e[OPW-1:0]});
      chk("bp_cout", {31'd0, cout}, {31'd0, last_e[OPW]});
    end
    sb_q.push_back(17'h3 + 17'h5);
    handshake();
    tick();
    in_valid = 1'b0;
    chk("bp_next_busy", {31'd0, busy}, 32'd1);
    wait_result(4);
    handshake();

    // Ignored input during RUN
    accept(16'h0001, 16'h0001, 1'b0, 1'b1);
    a = 16'hAAAA; b = 16'hAAAA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(3);
    handshake();
    tick();
    tick();
    chk("ign_idle_busy", {31'd0, busy}, 32'd0);
    chk("ign_sum_kept", {16'd0, sum}, 32'h0002);

    // Reset during slice 2
    accept(16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    accept(16'h0003, 16'h0004, 1'b0, 1'b1);
    wait_result(4);
    chk("post_rst_sum_const", {16'd0, sum}, 32'h0007);
    handshake();

`ifdef ADD_SEQ_SUB_EN
    accept(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_result(4);
    chk("sub_neg_const", {15'd0, cout, sum}, {15'd0, 1'b0, 16'hFFFE});
    handshake();
    accept(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_result(4);
    chk("sub_pos_const", {15'd0, cout, sum}, {15'd0, 1'b1, 16'h0002});
    handshake();
`endif

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
- Multi-cycle sequencer that adds two wide operands by reusing one WIDTH-bit adder slice over NSLICE consecutive cycles.
- Processes the least-significant slice first and carries between slices in a register.
- Sits between a valid/ready producer and a valid/ready consumer.
- Trades throughput for area against a full-width parallel adder built from the team's WIDTH-bit adder cells.

Parameters:
- WIDTH, 4, bits per adder slice (the datapath slice width); must be >= 1.
- NSLICE, 4, number of slices per operand; must be >= 1. Operand width OPW = WIDTH*NSLICE.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair a/b presented.
- in_ready  output  1  block can accept an operand pair.
- a  input  OPW  operand A, unsigned.
- b  input  OPW  operand B, unsigned.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  OPW  result bits [OPW-1:0].
- cout  output  1  carry out of the most-significant slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock domain. rst_n asserts asynchronously, deasserts synchronously to clk (external synchroniser).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, internal carry=0, slice counter=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE. All outputs come from registers or decode of the state register; no combinational path from input to output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a and b into shift registers, clear carry, counter=0, move to RUN.
  - in_valid low: stay in IDLE.
- RUN (exactly NSLICE cycles):
  - in_ready=0.
  - Each cycle: {c, s} = a_sh[WIDTH-1:0] + b_sh[WIDTH-1:0] + carry, computed at (WIDTH+1) bits.
  - s shifts into the top of the result register, so the first slice ends in bits [WIDTH-1:0] after NSLICE shifts.
  - a_sh/b_sh shift right by WIDTH. carry<=c. counter increments.
  - When counter==NSLICE-1: load cout<=c, set out_valid=1, move to DONE.
  - in_valid during RUN is ignored; the operands are not captured.
- DONE:
  - out_valid=1. sum and cout stay stable until the handshake.
  - On out_valid&&out_ready: out_valid<=0, move to IDLE.
  - in_ready=0 in DONE, so simultaneous in_valid is not accepted; it is taken the cycle after the return to IDLE.
- Latency: accept at edge T, out_valid high after edge T+NSLICE. Minimum initiation interval is NSLICE+2 cycles with out_ready held high.
- sum is updated only in RUN. It keeps the last result while in IDLE.
- NSLICE=1: RUN lasts one cycle, giving a plain registered add.
- Wrap-around: sum is modulo 2^OPW. The overflow bit goes only to cout.
- Reset mid-operation, in any state: abort immediately. Return to the reset values. The partial result is discarded and no out_valid pulse is produced.
- busy = (state!=IDLE).

Optional Feature:
- Macro ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a/b at acceptance.
  - When sub=1, b is captured inverted and the initial carry is 1, so the result is a-b modulo 2^OPW.
  - cout=1 means no borrow (a>=b).
- Not defined: no sub port; addition only; initial carry always 0.
- Latency and handshakes are identical in both builds.

Test Plan:
All cases use WIDTH=4, NSLICE=4.
- Basic add: a=0x1234, b=0x0FFF, out_ready=1 -> out_valid 4 cycles after accept; sum=0x2233, cout=0; busy high from accept until the result handshake.
- Full carry ripple: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0xFFFF -> sum=0xFFFE, cout=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> sum/cout/out_valid stay stable and in_ready stays 0; the next in_valid is accepted only after the handshake plus one cycle.
- Ignored input: pulse in_valid with a=0xAAAA during RUN of a 0x0001+0x0001 operation -> result 0x0002, and 0xAAAA is never processed.
- Reset mid-RUN: assert rst_n low at slice 2 of 0x1234+0x1111 -> out_valid, sum, cout, busy are 0 immediately and in_ready=1; a fresh 0x0003+0x0004 afterwards gives 0x0007.
- ADD_SEQ_SUB_EN build: sub=1 with a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. sub=1 with a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
